// File: rtl/mont_exp_ctrl_if.sv
// Operand bus and start/done handshake between the exponentiation sequencer
// (master) and a single Montgomery multiplier core (slave).
interface mont_exp_ctrl_if #(
    parameter int WIDTH = 512
);
    logic             mm_resetn;
    logic             mm_start;
    logic [WIDTH-1:0] mm_in_a;
    logic [WIDTH-1:0] mm_in_b;
    logic [WIDTH-1:0] mm_in_m;
    logic [WIDTH+1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_resetn, mm_start, mm_in_a, mm_in_b, mm_in_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_resetn, mm_start, mm_in_a, mm_in_b, mm_in_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply x^e mod M in the Montgomery domain, one core op at a time.
// Optional watchdog on the core's done: define MONT_EXP_TIMEOUT_EN (adds the err port).
module mont_exp_ctrl #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512,
    parameter int ELEN_W    = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x_mont,
    input  logic [WIDTH-1:0]     in_r_mod_m,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [ELEN_W-1:0]    in_e_len,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
`ifdef MONT_EXP_TIMEOUT_EN
    output logic                 err,
`endif
    mont_exp_ctrl_if.master      mm
);

    typedef enum logic [2:0] {IDLE, NEXT, MM_RST, MM_GO, MM_WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_SQR, OP_MUL, OP_CNV} op_t;

    localparam logic [ELEN_W-1:0]    ELEN_MAX = ELEN_W'(EXP_WIDTH);
    localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] E_ONE    = EXP_WIDTH'(1);

    state_t               state;
    op_t                  op;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     x_reg;
    logic [WIDTH-1:0]     m_reg;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [ELEN_W-1:0]    idx;
    logic                 core_rst_n_q;
    logic                 e_bit;
    logic [ELEN_W-1:0]    e_len_clamped;
    logic [WIDTH-1:0]     mm_res_low;
    logic                 unused_mm_hi;
`ifdef MONT_EXP_TIMEOUT_EN
    logic [15:0]          wd_cnt;
`endif

    assign e_bit         = |(e_reg & (E_ONE << idx));
    assign e_len_clamped = (in_e_len > ELEN_MAX) ? ELEN_MAX : in_e_len;
    assign mm_res_low    = mm.mm_result[WIDTH-1:0];
    // The core result is already below M, so its two guard bits carry no information.
    assign unused_mm_hi  = ^mm.mm_result[WIDTH+1:WIDTH];

    // The core is held in reset whenever this block is, on top of the per-op pulse.
    assign mm.mm_resetn  = resetn & core_rst_n_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            op            <= OP_SQR;
            acc           <= '0;
            x_reg         <= '0;
            m_reg         <= '0;
            e_reg         <= '0;
            idx           <= '0;
            result        <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            core_rst_n_q  <= 1'b1;
            mm.mm_start   <= 1'b0;
            mm.mm_in_a    <= '0;
            mm.mm_in_b    <= '0;
            mm.mm_in_m    <= '0;
`ifdef MONT_EXP_TIMEOUT_EN
            err           <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x_reg <= in_x_mont;
                        m_reg <= in_m;
                        e_reg <= in_e;
                        acc   <= in_r_mod_m;
                        idx   <= e_len_clamped;
                        done  <= 1'b0;
                        busy  <= 1'b1;
`ifdef MONT_EXP_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                        state <= NEXT;
                    end
                end
                // Operands are registered here so they stay put for the whole core op.
                NEXT: begin
                    if (idx == '0) begin
                        op         <= OP_CNV;
                        mm.mm_in_b <= ONE;
                    end else begin
                        idx        <= idx - ELEN_W'(1);
                        op         <= OP_SQR;
                        mm.mm_in_b <= acc;
                    end
                    mm.mm_in_a   <= acc;
                    mm.mm_in_m   <= m_reg;
                    core_rst_n_q <= 1'b0;
                    state        <= MM_RST;
                end
                MM_RST: begin
                    core_rst_n_q <= 1'b1;
                    mm.mm_start  <= 1'b1;
                    state        <= MM_GO;
                end
                MM_GO: begin
                    mm.mm_start <= 1'b0;
`ifdef MONT_EXP_TIMEOUT_EN
                    wd_cnt      <= '0;
`endif
                    state       <= MM_WAIT;
                end
                MM_WAIT: begin
                    if (mm.mm_done) begin
                        acc <= mm_res_low;
                        case (op)
                            OP_SQR: begin
                                if (e_bit) begin
                                    op           <= OP_MUL;
                                    mm.mm_in_a   <= mm_res_low;
                                    mm.mm_in_b   <= x_reg;
                                    core_rst_n_q <= 1'b0;
                                    state        <= MM_RST;
                                end else begin
                                    state <= NEXT;
                                end
                            end
                            OP_MUL: state <= NEXT;
                            default: begin
                                result <= mm_res_low;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= DONE;
                            end
                        endcase
                    end
`ifdef MONT_EXP_TIMEOUT_EN
                    else if (wd_cnt == 16'hFFFF) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery core plus a plain-arithmetic power-mod reference.
module tb_mont_exp_ctrl;
    localparam int W        = 512;
    localparam int EW       = 512;
    localparam int LW       = 10;
    localparam int CORE_LAT = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x_mont, in_r_mod_m, in_m;
    logic [EW-1:0] in_e;
    logic [LW-1:0] in_e_len;
    logic [W-1:0]  result;
    logic          done, busy;
`ifdef MONT_EXP_TIMEOUT_EN
    logic          err;
`endif

    mont_exp_ctrl_if #(.WIDTH(W)) mm_bus ();

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .ELEN_W(LW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_x_mont  (in_x_mont),
        .in_r_mod_m (in_r_mod_m),
        .in_m       (in_m),
        .in_e       (in_e),
        .in_e_len   (in_e_len),
        .result     (result),
        .done       (done),
        .busy       (busy),
`ifdef MONT_EXP_TIMEOUT_EN
        .err        (err),
`endif
        .mm         (mm_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [W+1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] m);
        logic [2*W+2:0] t;
        t = (2*W+3)'(a) * (2*W+3)'(b);
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + (2*W+3)'(m);
            t = t >> 1;
        end
        if (t >= (2*W+3)'(m)) t = t - (2*W+3)'(m);
        return t[W+1:0];
    endfunction

    // Core model: result appears CORE_LAT edges after the start pulse, done sticky until reset.
    logic core_hang = 1'b0;
    int   core_cnt;
    always @(posedge clk) begin
        if (mm_bus.mm_resetn !== 1'b1) begin
            mm_bus.mm_done   <= 1'b0;
            mm_bus.mm_result <= '0;
            core_cnt         <= 0;
        end else if (mm_bus.mm_start === 1'b1) begin
            mm_bus.mm_result <= mont_mul(mm_bus.mm_in_a, mm_bus.mm_in_b, mm_bus.mm_in_m);
            core_cnt         <= CORE_LAT;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_hang) mm_bus.mm_done <= 1'b1;
        end
    end

    // Handshake monitor: counts start pulses, per-op reset cycles and starts lacking a reset before them.
    int           op_count = 0;
    int           rst_low_count = 0;
    int           bad_go = 0;
    logic         prev_core_rst = 1'b0;
    logic [W-1:0] last_a, last_b, last_m;
    always @(negedge clk) begin
        if (mm_bus.mm_start === 1'b1) begin
            op_count++;
            last_a = mm_bus.mm_in_a;
            last_b = mm_bus.mm_in_b;
            last_m = mm_bus.mm_in_m;
            if (!prev_core_rst) bad_go++;
        end
        if (resetn === 1'b1 && mm_bus.mm_resetn === 1'b0) rst_low_count++;
        prev_core_rst = (mm_bus.mm_resetn === 1'b0);
    end

    function automatic longint r_mod_of(input longint m);
        longint r = 1;
        for (int i = 0; i < W; i++) r = (r * 2) % m;
        return r;
    endfunction

    function automatic longint pow_mod(input longint x, input logic [EW-1:0] e, input int n,
                                       input longint m);
        longint res = 1 % m;
        longint b = x % m;
        for (int i = 0; i < n; i++) begin
            if (e[i]) res = (res * b) % m;
            b = (b * b) % m;
        end
        return res;
    endfunction

    function automatic int ops_for(input logic [EW-1:0] e, input int n);
        int cnt = n + 1;
        for (int i = 0; i < n; i++) cnt += int'(e[i]);
        return cnt;
    endfunction

    task automatic checkOutput(input string tag, input logic [W+1:0] observed,
                               input logic [W+1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] x_mont, input logic [W-1:0] r_mod,
                                 input logic [W-1:0] m, input logic [EW-1:0] e,
                                 input logic [LW-1:0] e_len);
        @(negedge clk);
        in_x_mont  = x_mont;
        in_r_mod_m = r_mod;
        in_m       = m;
        in_e       = e;
        in_e_len   = e_len;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, W'(done), W'(1));
    endtask

    task automatic runCase(input string tag, input longint x, input longint m,
                           input logic [EW-1:0] e, input int e_len);
        longint r, xm, expect_res;
        int     eff, expect_ops, ops0, rst0, bad0;
        r          = r_mod_of(m);
        xm         = (x * r) % m;
        eff        = (e_len > EW) ? EW : e_len;
        expect_res = pow_mod(x, e, eff, m);
        expect_ops = ops_for(e, eff);
        ops0       = op_count;
        rst0       = rst_low_count;
        bad0       = bad_go;
        applyStimulus(W'(xm), W'(r), W'(m), e, LW'(e_len));
        checkOutput({tag, "_busy"}, W'(busy), W'(1));
        waitDone(tag, expect_ops * (CORE_LAT + 8) + 20);
        checkOutput({tag, "_result"}, W'(result), W'(expect_res));
        checkOutput({tag, "_ops"}, W'(op_count - ops0), W'(expect_ops));
        checkOutput({tag, "_rst_pulses"}, W'(rst_low_count - rst0), W'(expect_ops));
        checkOutput({tag, "_go_wo_rst"}, W'(bad_go - bad0), W'(0));
        checkOutput({tag, "_busy_end"}, W'(busy), W'(0));
    endtask

    function automatic logic [EW-1:0] rand_e();
        logic [EW-1:0] v;
        for (int i = 0; i < EW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int ops0;
        longint rm, xm;
        logic [EW-1:0] e_r;

        resetn     = 1'b0;
        start      = 1'b0;
        in_x_mont  = '0;
        in_r_mod_m = '0;
        in_m       = '0;
        in_e       = '0;
        in_e_len   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_result", W'(result), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_mm_start", W'(mm_bus.mm_start), W'(0));
        checkOutput("rst_mm_resetn", W'(mm_bus.mm_resetn), W'(0));
        checkOutput("rst_mm_in_a", W'(mm_bus.mm_in_a), W'(0));
        resetn = 1'b1;
        @(negedge clk);

        // 2^5 mod 13: three squares, two multiplies, one conversion.
        runCase("t1", 2, 13, EW'(5), 3);
        checkOutput("t1_mm_in_m", W'(last_m), W'(13));

        runCase("t2", 2, 13, EW'(5), 0);
        checkOutput("t2_a", W'(last_a), W'(9));
        checkOutput("t2_b", W'(last_b), W'(1));

        runCase("t3a", 2, 13, EW'(0), 4);
        applyStimulus(W'(5), W'(9), W'(13), EW'(1), LW'(1));
        checkOutput("t3b_done_drop", W'(done), W'(0));
        checkOutput("t3b_result_hold", W'(result), W'(1));
        waitDone("t3b", 200);
        checkOutput("t3b_result", W'(result), W'(2));

        // Inputs and start are changed while the run is in flight; neither may affect it.
        ops0 = op_count;
        applyStimulus(W'(5), W'(9), W'(13), EW'(5), LW'(3));
        repeat (3) @(negedge clk);
        in_e      = rand_e();
        in_x_mont = W'($urandom_range(0, 12));
        in_e_len  = LW'(7);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        checkOutput("t4_busy", W'(busy), W'(1));
        waitDone("t4", 200);
        checkOutput("t4_result", W'(result), W'(6));
        checkOutput("t4_ops", W'(op_count - ops0), W'(6));

        // Reset lands in the third core wait.
        ops0 = op_count;
        applyStimulus(W'(5), W'(9), W'(13), EW'(5), LW'(3));
        for (int n = 0; n < 200 && op_count - ops0 < 3; n++) @(negedge clk);
        checkOutput("t5_reached_op3", W'(op_count - ops0), W'(3));
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_done", W'(done), W'(0));
        checkOutput("t5_busy", W'(busy), W'(0));
        checkOutput("t5_result", W'(result), W'(0));
        checkOutput("t5_mm_resetn", W'(mm_bus.mm_resetn), W'(0));
        checkOutput("t5_mm_start", W'(mm_bus.mm_start), W'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        runCase("t5_rerun", 2, 13, EW'(5), 3);

        for (int k = 0; k < 6; k++) begin
            rm  = longint'($urandom_range(1, 1 << 19)) * 2 + 1;
            xm  = longint'($urandom) % rm;
            e_r = rand_e();
            runCase($sformatf("rnd%0d", k), xm, rm, e_r, $urandom_range(0, 20));
        end

        // Exponent length beyond the register width is clamped to the full width.
        rm  = longint'($urandom_range(1, 1 << 19)) * 2 + 1;
        e_r = rand_e();
        runCase("clamp", longint'($urandom) % rm, rm, e_r, 600);

`ifdef MONT_EXP_TIMEOUT_EN
        core_hang = 1'b1;
        applyStimulus(W'(5), W'(9), W'(13), EW'(0), LW'(0));
        waitDone("wd", 70000);
        checkOutput("wd_err", W'(err), W'(1));
        checkOutput("wd_result", W'(result), W'(0));
        core_hang = 1'b0;
        applyStimulus(W'(5), W'(9), W'(13), EW'(5), LW'(3));
        checkOutput("wd_err_clear", W'(err), W'(0));
        waitDone("wd_rerun", 200);
        checkOutput("wd_rerun_result", W'(result), W'(6));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
